// File: rtl/i2c_master_wr.sv
// I2C write-only master: START, 1..MAX_BYTES bytes MSB-first with ACK slots, STOP.
// Reports per-byte ACK status and optionally aborts to STOP on the first NACK.
module i2c_master_wr #(
  parameter int MAX_BYTES     = 3,
  parameter int DIV_BITS      = 7,
  parameter bit ABORT_ON_NACK = 1'b1,
  localparam int LEN_W        = $clog2(MAX_BYTES + 1)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [LEN_W-1:0]       len,
  input  logic [8*MAX_BYTES-1:0] i2c_data,
  output logic                   busy,
  output logic                   done,
  output logic                   ack,
  output logic [MAX_BYTES-1:0]   ack_mask,
  output logic                   i2c_sclk,
  inout  wire                    i2c_sdat
);

  localparam int                IDX_W   = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
  localparam int                TOP     = 8*MAX_BYTES - 1;
  localparam logic [DIV_BITS-1:0] QTR   = DIV_BITS'((1 << (DIV_BITS-2)) - 1);
  localparam logic [LEN_W-1:0]  MAX_LEN = LEN_W'(MAX_BYTES);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_BIT, S_ACK, S_STOP_LO, S_STOP_HI
  } state_t;

  state_t                state_q, state_d;
  logic [DIV_BITS-1:0]   div_q, div_d;
  logic                  clk_en_q, clk_en_d;
  logic                  sda_oe_q, sda_oe_d;
  logic [2:0]            bit_q, bit_d;
  logic [IDX_W-1:0]      byte_q, byte_d;
  logic [MAX_BYTES-1:0]  mask_q, mask_d;
  logic                  ack_q, ack_d;
  logic                  nack_q, nack_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [LEN_W-1:0]      len_q, len_d;
  logic [8*MAX_BYTES-1:0] data_q, data_d;

  logic quarter, wrap, len_ok, last_byte, sda_in;

  assign quarter   = (div_q == QTR);
  assign wrap      = &div_q;
  assign len_ok    = (len != '0) && (len <= MAX_LEN);
  assign last_byte = ((LEN_W'(byte_q) + LEN_W'(1)) == len_q);
  assign sda_in    = i2c_sdat;

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    clk_en_d = clk_en_q;
    sda_oe_d = sda_oe_q;
    bit_d    = bit_q;
    byte_d   = byte_q;
    mask_d   = mask_q;
    ack_d    = ack_q;
    nack_d   = nack_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    len_d    = len_q;
    data_d   = data_q;

    if (state_q != S_IDLE) div_d = div_q + DIV_BITS'(1);

    case (state_q)
      S_IDLE: begin
        div_d    = '0;
        clk_en_d = 1'b0;
        sda_oe_d = 1'b0;
        if (start && len_ok) begin
          state_d = S_START;
          busy_d  = 1'b1;
          mask_d  = '0;
          ack_d   = 1'b0;
          nack_d  = 1'b0;
          bit_d   = '0;
          byte_d  = '0;
          len_d   = len;
          data_d  = i2c_data;
        end
      end
      S_START: begin
        // SDA falls while SCL is still high: the START condition.
        if (quarter) sda_oe_d = 1'b1;
        if (wrap) begin
          clk_en_d = 1'b1;
          state_d  = S_BIT;
        end
      end
      S_BIT: begin
        if (quarter) begin
          sda_oe_d = ~data_q[TOP];
          data_d   = data_q << 1;
        end
        if (wrap) begin
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = S_ACK;
        end
      end
      S_ACK: begin
        if (quarter) sda_oe_d = 1'b0;
        if (wrap) begin
          if (!sda_in) mask_d[byte_q] = 1'b1;
          else         nack_d         = 1'b1;
          if (last_byte || (sda_in && ABORT_ON_NACK)) begin
            state_d = S_STOP_LO;
          end else begin
            state_d = S_BIT;
            byte_d  = byte_q + IDX_W'(1);
          end
        end
      end
      S_STOP_LO: begin
        if (quarter) sda_oe_d = 1'b1;
        if (wrap) begin
          clk_en_d = 1'b0;
          state_d  = S_STOP_HI;
        end
      end
      S_STOP_HI: begin
        // SDA rises while SCL is held high: the STOP condition.
        if (quarter) sda_oe_d = 1'b0;
        if (wrap) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          ack_d   = ~nack_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      div_q    <= '0;
      clk_en_q <= 1'b0;
      sda_oe_q <= 1'b0;
      bit_q    <= '0;
      byte_q   <= '0;
      mask_q   <= '0;
      ack_q    <= 1'b0;
      nack_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      clk_en_q <= clk_en_d;
      sda_oe_q <= sda_oe_d;
      bit_q    <= bit_d;
      byte_q   <= byte_d;
      mask_q   <= mask_d;
      ack_q    <= ack_d;
      nack_q   <= nack_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Payload and length are only meaningful while busy, so they carry no reset.
  always_ff @(posedge clk) begin
    len_q  <= len_d;
    data_q <= data_d;
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign ack      = ack_q;
  assign ack_mask = mask_q;
  assign i2c_sclk = ~clk_en_q | div_q[DIV_BITS-1];
  assign i2c_sdat = sda_oe_q ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_master_wr.sv
// Bench for i2c_master_wr: two instances (abort / no-abort on NACK) share stimulus;
// a bus-level slave model feeds a scoreboard of expected bytes and completion status.
module tb_i2c_master_wr;

  localparam int P = 16;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [1:0]  len;
  logic [23:0] i2c_data;
  logic [1:0]  busy_v, done_v, ack_v, scl_v;
  logic [2:0]  mask_v [2];
  wire         sda0, sda1;
  logic [1:0]  sdrv;

  pullup pu0 (sda0);
  pullup pu1 (sda1);
  assign sda0 = sdrv[0] ? 1'b0 : 1'bz;
  assign sda1 = sdrv[1] ? 1'b0 : 1'bz;

  i2c_master_wr #(.MAX_BYTES(3), .DIV_BITS(4), .ABORT_ON_NACK(1'b1)) u_dut_abort (
    .clk(clk), .reset_n(reset_n), .start(start), .len(len), .i2c_data(i2c_data),
    .busy(busy_v[0]), .done(done_v[0]), .ack(ack_v[0]), .ack_mask(mask_v[0]),
    .i2c_sclk(scl_v[0]), .i2c_sdat(sda0)
  );

  i2c_master_wr #(.MAX_BYTES(3), .DIV_BITS(4), .ABORT_ON_NACK(1'b0)) u_dut_noabort (
    .clk(clk), .reset_n(reset_n), .start(start), .len(len), .i2c_data(i2c_data),
    .busy(busy_v[1]), .done(done_v[1]), .ack(ack_v[1]), .ack_mask(mask_v[1]),
    .i2c_sclk(scl_v[1]), .i2c_sdat(sda1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       a;
    logic [2:0] m;
    int         cyc;
    int         nb;
  } exp_t;

  logic [7:0] exp_byte_q [2][$];
  exp_t       exp_done_q [2][$];

  int n_checks = 0;
  int n_errors = 0;
  int nack_idx = -1;

  logic [1:0] scl_p = 2'b11, sda_p = 2'b11, busy_p = 2'b00, in_frame = 2'b00;
  int         bitcnt [2];
  int         byte_idx [2];
  int         nbytes [2];
  int         cyc [2];
  logic [7:0] shreg [2];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_fail(input string name, input int act);
    n_checks++;
    n_errors++;
    $display("FAIL %s: got %0d with nothing expected", name, act);
  endtask

  task automatic expect_txn(input int g, input logic [23:0] d, input int nb,
                            input logic a, input logic [2:0] m, input int cyc_exp);
    logic [23:0] t;
    exp_t        e;
    t = d;
    for (int i = 0; i < nb; i++) exp_byte_q[g].push_back(t[23-8*i -: 8]);
    e.a = a; e.m = m; e.cyc = cyc_exp; e.nb = nb;
    exp_done_q[g].push_back(e);
  endtask

  // Slave model, protocol checker and scoreboard consumer for instance g.
  task automatic mon_step(input int g);
    logic       scl, sda, bsy, dn;
    logic [7:0] eb;
    exp_t       e;
    scl = scl_v[g];
    sda = (g == 0) ? sda0 : sda1;
    bsy = busy_v[g];
    dn  = done_v[g];
    if (!reset_n) begin
      in_frame[g] = 1'b0;
      bitcnt[g]   = 0;
      sdrv[g]     = 1'b0;
    end else begin
      if (bsy && !busy_p[g]) cyc[g] = 0;
      else                   cyc[g]++;
      if (scl && scl_p[g] && (sda != sda_p[g])) begin
        if (!sda) begin
          chk($sformatf("start_inside_frame_%0d", g), int'(in_frame[g]), 0);
          in_frame[g] = 1'b1;
          bitcnt[g]   = 0;
          byte_idx[g] = 0;
          nbytes[g]   = 0;
        end else begin
          chk($sformatf("stop_outside_frame_%0d", g), int'(in_frame[g]), 1);
          in_frame[g] = 1'b0;
          sdrv[g]     = 1'b0;
        end
      end else if (in_frame[g] && scl && !scl_p[g]) begin
        if (bitcnt[g] < 8) begin
          shreg[g] = {shreg[g][6:0], sda};
          bitcnt[g]++;
          if (bitcnt[g] == 8) begin
            nbytes[g]++;
            if (exp_byte_q[g].size() == 0) begin
              chk_fail($sformatf("unexpected_byte_%0d", g), int'(shreg[g]));
            end else begin
              eb = exp_byte_q[g].pop_front();
              chk($sformatf("bus_byte_%0d", g), int'(shreg[g]), int'(eb));
            end
          end
        end else if (bitcnt[g] == 8) begin
          bitcnt[g] = 9;
        end
      end else if (in_frame[g] && !scl && scl_p[g]) begin
        if (bitcnt[g] == 8) begin
          sdrv[g] = (byte_idx[g] != nack_idx);
        end else if (bitcnt[g] == 9) begin
          sdrv[g]   = 1'b0;
          bitcnt[g] = 0;
          byte_idx[g]++;
        end
      end
      if (dn) begin
        if (exp_done_q[g].size() == 0) begin
          chk_fail($sformatf("unexpected_done_%0d", g), int'(mask_v[g]));
        end else begin
          e = exp_done_q[g].pop_front();
          chk($sformatf("done_ack_%0d", g),     int'(ack_v[g]),  int'(e.a));
          chk($sformatf("done_mask_%0d", g),    int'(mask_v[g]), int'(e.m));
          chk($sformatf("done_cycles_%0d", g),  cyc[g],          e.cyc);
          chk($sformatf("bytes_on_bus_%0d", g), nbytes[g],       e.nb);
        end
      end
    end
    scl_p[g]  = scl;
    sda_p[g]  = sda;
    busy_p[g] = bsy;
  endtask

  initial begin : monitor
    sdrv = 2'b00;
    forever begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) mon_step(g);
    end
  end

  task automatic issue(input logic [1:0] l, input logic [23:0] d);
    start    = 1'b1;
    len      = l;
    i2c_data = d;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 1500; i++) begin
      if (busy_v == 2'b00) break;
      @(negedge clk);
    end
    chk("txn_completes_in_budget", int'(busy_v), 0);
  endtask

  task automatic check_idle_bus(input string tag);
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("%s_scl_%0d", tag, g),  int'(scl_v[g]),  1);
      chk($sformatf("%s_sda_%0d", tag, g),  int'((g == 0) ? sda0 : sda1), 1);
      chk($sformatf("%s_busy_%0d", tag, g), int'(busy_v[g]), 0);
      chk($sformatf("%s_done_%0d", tag, g), int'(done_v[g]), 0);
      chk($sformatf("%s_mask_%0d", tag, g), int'(mask_v[g]), 0);
    end
  endtask

  initial begin : stimulus
    logic seen_busy, seen_scl_low;
    reset_n  = 1'b0;
    start    = 1'b0;
    len      = 2'd0;
    i2c_data = 24'h0;
    repeat (5) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check_idle_bus("reset");
    chk("reset_ack_0", int'(ack_v[0]), 0);
    chk("reset_ack_1", int'(ack_v[1]), 0);

    // Three bytes, all ACKed.
    expect_txn(0, 24'h341E00, 3, 1'b1, 3'b111, 30*P);
    expect_txn(1, 24'h341E00, 3, 1'b1, 3'b111, 30*P);
    issue(2'd3, 24'h341E00);
    wait_idle();
    @(negedge clk);

    // NACK on byte 1: instance 0 aborts, instance 1 keeps going.
    nack_idx = 1;
    expect_txn(0, 24'h341E00, 2, 1'b0, 3'b001, 21*P);
    expect_txn(1, 24'h341E00, 3, 1'b0, 3'b101, 30*P);
    issue(2'd3, 24'h341E00);
    wait_idle();
    nack_idx = -1;
    @(negedge clk);

    // Single byte, a start pulse while busy, then a back-to-back transaction.
    expect_txn(0, 24'hA50000, 1, 1'b1, 3'b001, 12*P);
    expect_txn(1, 24'hA50000, 1, 1'b1, 3'b001, 12*P);
    issue(2'd1, 24'hA50000);
    repeat (60) @(negedge clk);
    issue(2'd2, 24'hFFFFFF);
    wait_idle();
    expect_txn(0, 24'h5AC300, 2, 1'b1, 3'b011, 21*P);
    expect_txn(1, 24'h5AC300, 2, 1'b1, 3'b011, 21*P);
    issue(2'd2, 24'h5AC300);
    wait_idle();
    @(negedge clk);

    // len=0 must be ignored entirely.
    seen_busy    = 1'b0;
    seen_scl_low = 1'b0;
    issue(2'd0, 24'h123456);
    repeat (40) begin
      seen_busy    = seen_busy | (busy_v != 2'b00);
      seen_scl_low = seen_scl_low | (scl_v != 2'b11);
      @(negedge clk);
    end
    chk("len0_busy_seen", int'(seen_busy), 0);
    chk("len0_scl_activity", int'(seen_scl_low), 0);

    // Reset in the middle of byte 0.
    issue(2'd3, 24'h55AA55);
    repeat (50) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check_idle_bus("midreset");
    reset_n = 1'b1;
    @(negedge clk);

    // Recovery after the abandoned transfer.
    expect_txn(0, 24'h817E00, 2, 1'b1, 3'b011, 21*P);
    expect_txn(1, 24'h817E00, 2, 1'b1, 3'b011, 21*P);
    issue(2'd2, 24'h817E00);
    wait_idle();
    repeat (5) @(negedge clk);

    for (int g = 0; g < 2; g++) begin
      chk($sformatf("bytes_left_%0d", g), exp_byte_q[g].size(), 0);
      chk($sformatf("dones_left_%0d", g), exp_done_q[g].size(), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached with %0d checks", n_checks);
    $fatal(1);
  end

endmodule
